// File: rtl/opsum_drain.sv
// Drains the per-column opsum FIFOs of conv_unit into the GLB, token-major and
// column-ascending, sharing the GLB write port through a req/gnt handshake.
module opsum_drain #(
  parameter int NUM_COL = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [31:0]               base_addr_i,
  input  logic [31:0]               col_stride_i,
  input  logic [NUM_COL-1:0]        col_mask_i,
  input  logic [CNT_W-1:0]          tokens_i,
  input  logic [NUM_COL-1:0]        opsum_fifo_empty_matrix_i,
  input  logic [NUM_COL*DATA_W-1:0] opsum_fifo_pop_data_matrix_i,
  output logic [NUM_COL-1:0]        opsum_fifo_pop_matrix_o,
  output logic                      glb_req_o,
  input  logic                      glb_gnt_i,
  output logic [3:0]                glb_web_o,
  output logic [31:0]               glb_addr_o,
  output logic [DATA_W-1:0]         glb_write_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                dbg_state_o
);

  localparam int COL_W = $clog2(NUM_COL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        base_q;
  logic [31:0]        stride_q;
  logic [31:0]        addr_q;
  logic [NUM_COL-1:0] mask_q;
  logic [CNT_W-1:0]   tokens_q;
  logic [CNT_W-1:0]   tok_q;
  logic [COL_W-1:0]   col_q;

  logic               run;
  logic               cur_empty;
  logic [DATA_W-1:0]  cur_data;
  logic               commit;
  logic               last_word;
  logic [COL_W-1:0]   first_col;
  logic [COL_W-1:0]   wrap_col;
  logic [COL_W-1:0]   next_col;
  logic               has_next;
  logic [CNT_W-1:0]   tok_nxt;

  // Valid/ready contract on the GLB port: glb_req_o is the valid, glb_gnt_i the
  // ready; a word transfers (and its FIFO pops) on the cycle both are high, and
  // while req waits for gnt the address, data and web do not change.
  assign run       = (state_q == RUN);
  assign cur_empty = opsum_fifo_empty_matrix_i[col_q];
  assign commit    = run & ~cur_empty & glb_gnt_i;
  assign last_word = ~has_next & (tok_q == tokens_q - 1'b1);
  assign tok_nxt   = tok_q + 1'b1;

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (col_q == COL_W'(i)) cur_data = opsum_fifo_pop_data_matrix_i[i*DATA_W +: DATA_W];
    end
  end

  // Descending scans leave the lowest qualifying index in each result.
  always_comb begin
    first_col = '0;
    wrap_col  = '0;
    next_col  = '0;
    has_next  = 1'b0;
    for (int i = NUM_COL - 1; i >= 0; i--) begin
      if (col_mask_i[i]) first_col = COL_W'(i);
      if (mask_q[i]) wrap_col = COL_W'(i);
      if (mask_q[i] && (COL_W'(i) > col_q)) begin
        next_col = COL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  assign glb_req_o               = run & ~cur_empty;
  assign glb_web_o               = glb_req_o ? 4'b0000 : 4'b1111;
  assign glb_addr_o              = addr_q;
  assign glb_write_data_o        = run ? cur_data : '0;
  assign opsum_fifo_pop_matrix_o = commit ? (NUM_COL'(1) << col_q) : '0;
  assign busy_o                  = run;
  assign done_o                  = (state_q == DONE);
  assign dbg_state_o             = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      tokens_q <= '0;
      tok_q    <= '0;
      col_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q   <= base_addr_i;
            stride_q <= col_stride_i;
            mask_q   <= col_mask_i;
            tokens_q <= tokens_i;
            tok_q    <= '0;
            col_q    <= first_col;
            addr_q   <= base_addr_i + (32'(first_col) * col_stride_i);
            if ((col_mask_i == '0) || (tokens_i == '0)) state_q <= DONE;
            else                                        state_q <= RUN;
          end
        end
        RUN: begin
          if (commit) begin
            if (last_word) begin
              state_q <= DONE;
            end else if (has_next) begin
              col_q  <= next_col;
              addr_q <= base_q + (32'(next_col) * stride_q) + 32'(tok_q);
            end else begin
              col_q  <= wrap_col;
              tok_q  <= tok_nxt;
              addr_q <= base_q + (32'(wrap_col) * stride_q) + 32'(tok_nxt);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opsum_drain.sv
// Bench for opsum_drain: FIFO and GLB models around the DUT, with a scoreboard
// whose expected write stream is built from the token-major drain order.
module tb_opsum_drain;

  localparam int NUM_COL = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  logic                      clk;
  logic                      rst_n;
  logic                      start_i;
  logic [31:0]               base_addr_i;
  logic [31:0]               col_stride_i;
  logic [NUM_COL-1:0]        col_mask_i;
  logic [CNT_W-1:0]          tokens_i;
  logic [NUM_COL-1:0]        fifo_empty;
  logic [NUM_COL*DATA_W-1:0] fifo_data;
  logic [NUM_COL-1:0]        fifo_pop;
  logic                      glb_req;
  logic                      glb_gnt_i;
  logic [3:0]                glb_web;
  logic [31:0]               glb_addr;
  logic [DATA_W-1:0]         glb_wdata;
  logic                      busy;
  logic                      done;
  logic [1:0]                dbg_state;

  opsum_drain #(.NUM_COL(NUM_COL), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .start_i                      (start_i),
    .base_addr_i                  (base_addr_i),
    .col_stride_i                 (col_stride_i),
    .col_mask_i                   (col_mask_i),
    .tokens_i                     (tokens_i),
    .opsum_fifo_empty_matrix_i    (fifo_empty),
    .opsum_fifo_pop_data_matrix_i (fifo_data),
    .opsum_fifo_pop_matrix_o      (fifo_pop),
    .glb_req_o                    (glb_req),
    .glb_gnt_i                    (glb_gnt_i),
    .glb_web_o                    (glb_web),
    .glb_addr_o                   (glb_addr),
    .glb_write_data_o             (glb_wdata),
    .busy_o                       (busy),
    .done_o                       (done),
    .dbg_state_o                  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- models and scoreboard ----------------
  logic [DATA_W-1:0] fifo_mem [NUM_COL][16];
  int                fifo_rd  [NUM_COL];
  int                fifo_cnt [NUM_COL];
  logic [68:0]       exp_q[$];  // {col[4:0], addr[31:0], data[31:0]}

  int          n_tests, n_fail;
  logic [31:0] cfg_base, cfg_stride, cfg_mask;
  int          cfg_tokens;
  int          hold_col, hold_until, gnt_lo, gnt_hi, spur_start_cyc, rst_cyc;
  bit          rand_gnt;
  int          done_cyc, first_cyc, last_cyc, n_commits;

  task automatic clear_opts();
    hold_col = -1; hold_until = -1; gnt_lo = -1; gnt_hi = -2;
    spur_start_cyc = -1; rst_cyc = -1; rand_gnt = 1'b0;
  endtask

  // Enabled columns get exactly `tokens` words; disabled ones get a few decoys.
  task automatic load_fifos();
    for (int c = 0; c < NUM_COL; c++) begin
      fifo_rd[c]  = 0;
      fifo_cnt[c] = cfg_mask[c] ? cfg_tokens : int'($urandom_range(0, 2));
      for (int k = 0; k < 16; k++) fifo_mem[c][k] = $urandom;
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int t = 0; t < cfg_tokens; t++)
      for (int c = 0; c < NUM_COL; c++)
        if (cfg_mask[c])
          exp_q.push_back({5'(c), cfg_base + 32'(c) * cfg_stride + 32'(t), fifo_mem[c][t]});
  endtask

  task automatic drive_fifo_inputs(input int cyc);
    for (int c = 0; c < NUM_COL; c++) begin
      fifo_empty[c] = (fifo_rd[c] >= fifo_cnt[c]) || (c == hold_col && cyc <= hold_until);
      fifo_data[c*DATA_W +: DATA_W] = fifo_mem[c][fifo_rd[c] % 16];
    end
  endtask

  task automatic set_cfg(input logic [31:0] mask, input int tokens,
                         input logic [31:0] base, input logic [31:0] stride);
    cfg_mask = mask; cfg_tokens = tokens; cfg_base = base; cfg_stride = stride;
    load_fifos();
    build_expected();
  endtask

  // Pulses start at cycle 0 and watches every cycle until done_o (or a budget).
  task automatic run_xfer(input int max_cyc, input bit skip_sync);
    int cyc, drained_at, ccol;
    bit exp_busy, exp_req, exp_done, commit, aborted;
    logic [68:0] head;
    logic [NUM_COL-1:0] exp_pop;
    if (!skip_sync) begin @(posedge clk); #1; end
    start_i = 1'b1; base_addr_i = cfg_base; col_stride_i = cfg_stride;
    col_mask_i = cfg_mask; tokens_i = CNT_W'(cfg_tokens);
    cyc = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1; n_commits = 0; aborted = 1'b0;
    drained_at = (exp_q.size() == 0) ? 0 : -1;
    while (done_cyc < 0 && cyc < max_cyc && !aborted) begin
      if (cyc > 0) begin
        start_i = (cyc == spur_start_cyc);
        base_addr_i = $urandom; col_stride_i = $urandom; col_mask_i = $urandom;
        tokens_i = CNT_W'($urandom_range(1, 9));
      end
      glb_gnt_i = rand_gnt ? ($urandom_range(0, 3) != 0) : !(cyc >= gnt_lo && cyc <= gnt_hi);
      drive_fifo_inputs(cyc);
      if (cyc == rst_cyc) begin
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({fifo_pop, glb_req, glb_web, glb_addr, glb_wdata, busy, done} !==
            {32'b0, 1'b0, 4'hF, 32'b0, 32'b0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL async_reset: pop=%h req=%b web=%h addr=%h data=%h busy=%b done=%b, need all at reset values",
                   fifo_pop, glb_req, glb_web, glb_addr, glb_wdata, busy, done);
        end
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        head     = (exp_q.size() > 0) ? exp_q[0] : '0;
        ccol     = int'(head[68:64]);
        exp_busy = (cyc >= 1) && (drained_at < 0);
        exp_req  = exp_busy && !fifo_empty[ccol];
        exp_done = (drained_at >= 0) && (cyc == drained_at + 1);
        n_tests++;
        if ({busy, glb_req, done} !== {exp_busy, exp_req, exp_done}) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d: busy/req/done=%b%b%b, need %b%b%b",
                   cyc, busy, glb_req, done, exp_busy, exp_req, exp_done);
        end
        n_tests++;
        if (glb_web !== (exp_req ? 4'h0 : 4'hF)) begin
          n_fail++;
          $display("FAIL web cyc=%0d: got %h need %h", cyc, glb_web, exp_req ? 4'h0 : 4'hF);
        end
        if (exp_req) begin
          n_tests++;
          if (glb_addr !== head[63:32] || glb_wdata !== head[31:0]) begin
            n_fail++;
            $display("FAIL write cyc=%0d col=%0d: addr=%h data=%h, need addr=%h data=%h",
                     cyc, ccol, glb_addr, glb_wdata, head[63:32], head[31:0]);
          end
        end
        commit  = exp_req && glb_gnt_i;
        exp_pop = commit ? (NUM_COL'(1) << ccol) : '0;
        n_tests++;
        if (fifo_pop !== exp_pop) begin
          n_fail++;
          $display("FAIL pop cyc=%0d: got %h need %h", cyc, fifo_pop, exp_pop);
        end
        if (done === 1'b1) done_cyc = cyc;
        if (commit) begin
          void'(exp_q.pop_front());
          n_commits++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) drained_at = cyc;
        end
        @(posedge clk);
        if (commit) fifo_rd[ccol]++;
        #1;
        cyc++;
      end
    end
    start_i = 1'b0;
    if (!aborted && done_cyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done_o within %0d cycles", max_cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; glb_gnt_i = 1'b1;
    base_addr_i = 32'h1234; col_stride_i = 32'h10; col_mask_i = '1; tokens_i = 16'd3;
    cfg_mask = '1; cfg_tokens = 2; load_fifos(); drive_fifo_inputs(0);
    #3;
    n_tests++;
    if ({fifo_pop, glb_req, glb_web, glb_addr, glb_wdata, busy, done, dbg_state} !==
        {32'b0, 1'b0, 4'hF, 32'b0, 32'b0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_values: pop=%h req=%b web=%h addr=%h data=%h busy=%b done=%b st=%0d",
               fifo_pop, glb_req, glb_web, glb_addr, glb_wdata, busy, done, dbg_state);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_opts();
    spur_start_cyc = 9;  // start during DONE must be dropped
    set_cfg(32'h0000_000F, 2, 32'h3000, 32'h100);
    run_xfer(40, 1'b0);
    n_tests++;
    if (first_cyc !== 1 || last_cyc !== 8 || done_cyc !== 9 || n_commits !== 8) begin
      n_fail++;
      $display("FAIL basic_timing: first=%0d last=%0d done=%0d commits=%0d, need 1 8 9 8",
               first_cyc, last_cyc, done_cyc, n_commits);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || glb_req !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b req=%b st=%0d, need 0 0 0", busy, glb_req, dbg_state);
    end
  endtask

  task automatic test_gnt_stall();
    clear_opts();
    gnt_lo = 3; gnt_hi = 5;
    spur_start_cyc = 4;  // start during RUN must be dropped
    set_cfg(32'h0000_000F, 2, 32'h3000, 32'h100);
    run_xfer(40, 1'b0);
    n_tests++;
    if (first_cyc !== 1 || last_cyc !== 11 || done_cyc !== 12 || n_commits !== 8) begin
      n_fail++;
      $display("FAIL gnt_stall_timing: first=%0d last=%0d done=%0d commits=%0d, need 1 11 12 8",
               first_cyc, last_cyc, done_cyc, n_commits);
    end
  endtask

  task automatic test_empty_stall();
    clear_opts();
    hold_col = 2; hold_until = 7;
    set_cfg(32'h0000_000F, 2, 32'h3000, 32'h100);
    run_xfer(40, 1'b0);
    n_tests++;
    if (last_cyc !== 13 || done_cyc !== 14 || n_commits !== 8) begin
      n_fail++;
      $display("FAIL empty_stall_timing: last=%0d done=%0d commits=%0d, need 13 14 8",
               last_cyc, done_cyc, n_commits);
    end
  endtask

  task automatic test_sparse_mask();
    clear_opts();
    set_cfg(32'h8000_0001, 1, 32'h4000, 32'h40);
    run_xfer(20, 1'b0);
    n_tests++;
    if (first_cyc !== 1 || last_cyc !== 2 || done_cyc !== 3) begin
      n_fail++;
      $display("FAIL sparse_timing: first=%0d last=%0d done=%0d, need 1 2 3", first_cyc, last_cyc, done_cyc);
    end
  endtask

  task automatic test_empty_config();
    clear_opts();
    set_cfg(32'h0, 3, 32'h5000, 32'h10);
    run_xfer(10, 1'b0);
    n_tests++;
    if (done_cyc !== 1 || n_commits !== 0) begin
      n_fail++;
      $display("FAIL mask_zero: done=%0d commits=%0d, need 1 0", done_cyc, n_commits);
    end
    set_cfg(32'h0000_00FF, 0, 32'h5000, 32'h10);
    run_xfer(10, 1'b0);
    n_tests++;
    if (done_cyc !== 1 || n_commits !== 0) begin
      n_fail++;
      $display("FAIL tokens_zero: done=%0d commits=%0d, need 1 0", done_cyc, n_commits);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_opts();
    rst_cyc = 4;
    set_cfg(32'h0000_000F, 2, 32'h3000, 32'h100);
    run_xfer(40, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_opts();
    set_cfg(32'h0000_000F, 2, 32'h3000, 32'h100);
    run_xfer(40, 1'b0);
    n_tests++;
    if (first_cyc !== 1 || last_cyc !== 8 || done_cyc !== 9 || n_commits !== 8) begin
      n_fail++;
      $display("FAIL post_reset_rerun: first=%0d last=%0d done=%0d commits=%0d, need 1 8 9 8",
               first_cyc, last_cyc, done_cyc, n_commits);
    end
  endtask

  task automatic test_back_to_back();
    clear_opts();
    set_cfg(32'h0000_0006, 1, 32'h100, 32'h8);
    run_xfer(20, 1'b0);
    set_cfg(32'h8000_0001, 1, 32'h4000, 32'h40);
    run_xfer(20, 1'b1);  // start lands exactly two cycles after the last commit
    n_tests++;
    if (first_cyc !== 1 || done_cyc !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: first=%0d done=%0d, need 1 3", first_cyc, done_cyc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_opts();
      rand_gnt = 1'b1;
      hold_col = int'($urandom_range(0, NUM_COL - 1));
      hold_until = int'($urandom_range(2, 12));
      set_cfg((it == 0) ? 32'hFFFF_FFFF : ($urandom & $urandom), int'($urandom_range(1, 4)),
              $urandom, $urandom);
      run_xfer(3000, 1'b0);
      n_tests++;
      if (n_commits !== $countones(cfg_mask) * cfg_tokens ||
          (n_commits > 0 && done_cyc !== last_cyc + 1)) begin
        n_fail++;
        $display("FAIL random_%0d: commits=%0d need %0d, done=%0d last=%0d",
                 it, n_commits, $countones(cfg_mask) * cfg_tokens, done_cyc, last_cyc);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_opts();
    test_reset();
    test_basic();
    test_gnt_stall();
    test_empty_stall();
    test_sparse_mask();
    test_empty_config();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
